// File: rtl/shadow_reg_writer_pkg.sv
// Shared types for the shadowed-register write initiator.
// Optional readback check is enabled by SHADOW_REG_WRITER_READBACK_EN.
package shadow_reg_writer_pkg;

  typedef enum logic [2:0] {
    IDLE, STAGE, COMMIT, CHECK, READBACK, RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UPDATE   = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } rsp_err_t;

  typedef enum logic {
    PHASE_STAGE  = 1'b0,
    PHASE_COMMIT = 1'b1
  } wr_phase_t;

endpackage

// File: rtl/shadow_reg_writer_timeout.sv
// Per-phase wait counter; terminal count marks the last cycle a write may still be accepted.
module shadow_reg_writer_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Saturate at terminal count; the owner leaves the phase there anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i)                cnt_q <= '0;
    else if (clr_i)           cnt_q <= '0;
    else if (en_i && !tc_o)   cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/shadow_reg_writer.sv
// Two-phase (stage, commit) writer into a shadowed register with update-error check.
// Define SHADOW_REG_WRITER_READBACK_EN to add a readback compare after commit.
module shadow_reg_writer
  import shadow_reg_writer_pkg::*;
#(
  parameter int DW      = 5,
  parameter int AW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_data_i,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          wr_phase_o,
  input  logic          err_update_i,
  input  logic [DW-1:0] rd_data_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [1:0]    rsp_err_o
);

  state_t        state_q, state_d;
  rsp_err_t      err_q, err_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          accept, tm_clr, tm_en, tm_tc;

  assign accept = req_valid_i && req_ready_o;
  // Counter restarts on entry to each write phase.
  assign tm_clr = accept || (state_q == STAGE && wr_ready_i);
  assign tm_en  = wr_valid_o && !wr_ready_i;

  shadow_reg_writer_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tm_clr),
    .en_i  (tm_en),
    .tc_o  (tm_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q <= req_addr_i;
        data_q <= req_data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE:   if (accept) state_d = STAGE;
      STAGE: begin
        if (wr_ready_i) state_d = COMMIT;
        else if (tm_tc) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      COMMIT: begin
        if (wr_ready_i) state_d = CHECK;
        else if (tm_tc) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (err_update_i) begin
          state_d = RESP;
          err_d   = ERR_UPDATE;
        end else begin
`ifdef SHADOW_REG_WRITER_READBACK_EN
          state_d = READBACK;
`else
          state_d = RESP;
          err_d   = ERR_NONE;
`endif
        end
      end
`ifdef SHADOW_REG_WRITER_READBACK_EN
      READBACK: begin
        state_d = RESP;
        err_d   = (rd_data_i != data_q) ? ERR_MISMATCH : ERR_NONE;
      end
`endif
      RESP:   if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifndef SHADOW_REG_WRITER_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^rd_data_i;
`endif

  assign req_ready_o = (state_q == IDLE);
  assign wr_valid_o  = (state_q == STAGE) || (state_q == COMMIT);
  assign wr_phase_o  = (state_q == COMMIT) ? PHASE_COMMIT : PHASE_STAGE;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = err_q;

endmodule
